// File: rtl/fft16_output_reorder.sv
// fft16_output_reorder: double-buffers 4-lane digit-reversed radix-4 FFT frames
// and streams the 16 bins serially in natural order over valid/ready.
`default_nettype none

module fft16_output_reorder #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_first,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in_0,
   input  logic [DATA_W-1:0] data_in_1,
   input  logic [DATA_W-1:0] data_in_2,
   input  logic [DATA_W-1:0] data_in_3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic [3:0]        out_index,
   output logic              out_last,
   output logic              frame_err
);

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_e;

   bank_state_e       bank_st_q [2];
   bank_state_e       bank_st_d [2];
   logic              wr_bank_q, wr_bank_d;
   logic [1:0]        wr_beat_q, wr_beat_d;
   logic              rd_bank_q, rd_bank_d;
   logic [3:0]        rd_idx_q, rd_idx_d;
   logic              in_ready_q, in_ready_d;
   logic              frame_err_q, frame_err_d;
   logic [DATA_W-1:0] mem_q [2][16];

   logic              accept;
   logic              resync;
   logic [1:0]        beat;
   logic              rd_fire;

   assign accept  = in_valid & in_ready_q;
   assign resync  = accept & in_first & (wr_beat_q != 2'd0);
   // A resync restarts the frame: the accepted beat lands in slot 0.
   assign beat    = resync ? 2'd0 : wr_beat_q;
   assign rd_fire = out_valid & out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank_st_q[0] <= BANK_EMPTY;
         bank_st_q[1] <= BANK_EMPTY;
         wr_bank_q    <= 1'b0;
         wr_beat_q    <= 2'd0;
         rd_bank_q    <= 1'b0;
         rd_idx_q     <= 4'd0;
         in_ready_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         bank_st_q[0] <= bank_st_d[0];
         bank_st_q[1] <= bank_st_d[1];
         wr_bank_q    <= wr_bank_d;
         wr_beat_q    <= wr_beat_d;
         rd_bank_q    <= rd_bank_d;
         rd_idx_q     <= rd_idx_d;
         in_ready_q   <= in_ready_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      bank_st_d[0] = bank_st_q[0];
      bank_st_d[1] = bank_st_q[1];
      wr_bank_d    = wr_bank_q;
      wr_beat_d    = wr_beat_q;
      rd_bank_d    = rd_bank_q;
      rd_idx_d     = rd_idx_q;
      frame_err_d  = resync;

      if (accept) begin
         wr_beat_d = beat + 2'd1;
         if (beat == 2'd3) begin
            bank_st_d[wr_bank_q] = BANK_FULL;
            wr_bank_d            = ~wr_bank_q;
         end
      end

      if (rd_fire) begin
         rd_idx_d = rd_idx_q + 4'd1;
         if (rd_idx_q == 4'd15) begin
            bank_st_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d            = ~rd_bank_q;
         end
      end

      // Registered ready: a bank freed this edge is writable only next cycle.
      in_ready_d = (bank_st_d[wr_bank_d] == BANK_EMPTY);
   end

   // Bin k = 4*lane + beat, i.e. {lane, beat}.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_bank_q][{2'd0, beat}] <= data_in_0;
         mem_q[wr_bank_q][{2'd1, beat}] <= data_in_1;
         mem_q[wr_bank_q][{2'd2, beat}] <= data_in_2;
         mem_q[wr_bank_q][{2'd3, beat}] <= data_in_3;
      end
   end

   always_comb begin
      out_valid = (bank_st_q[rd_bank_q] == BANK_FULL);
      data_out  = '0;
      out_index = 4'd0;
      out_last  = 1'b0;
      if (out_valid) begin
         data_out  = mem_q[rd_bank_q][rd_idx_q];
         out_index = rd_idx_q;
         out_last  = (rd_idx_q == 4'd15);
      end
   end

   assign in_ready  = in_ready_q;
   assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fft16_output_reorder.sv
// tb_fft16_output_reorder: random frames into a frame-level reference model;
// a scoreboard monitor checks each emitted bin, stalls and reset behaviour.
`default_nettype none

module tb_fft16_output_reorder;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_first = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic [3:0]        out_index;
   logic              out_last;
   logic              frame_err;

   fft16_output_reorder #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .in_ready  (in_ready),
      .data_in_0 (d0),
      .data_in_1 (d1),
      .data_in_2 (d2),
      .data_in_3 (d3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_index (out_index),
      .out_last  (out_last),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                k;
   } exp_t;

   exp_t              expq[$];
   logic [DATA_W-1:0] mframe [16];
   int                mbeat = 0;
   int                exp_err = 0;
   int                seen_err = 0;
   int                vectors = 0;
   int                miscompares = 0;
   int                rdy_mode = 0;
   int                cur_run = 0;
   int                max_run = 0;
   int                ready_low = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   // Reference model: a frame is 16 bins; bin 4*l+b arrives on lane l of beat b.
   task automatic model_accept(input logic first, input logic [3:0][DATA_W-1:0] lanes);
      if (first && mbeat != 0) begin
         exp_err++;
         mbeat = 0;
      end
      for (int l = 0; l < 4; l++) mframe[4*l + mbeat] = lanes[l];
      mbeat++;
      if (mbeat == 4) begin
         for (int k = 0; k < 16; k++) expq.push_back('{data: mframe[k], k: k});
         mbeat = 0;
      end
   endtask

   task automatic drive_beat(input logic first, input logic [3:0][DATA_W-1:0] lanes);
      in_valid = 1'b1;
      in_first = first;
      d0 = lanes[0]; d1 = lanes[1]; d2 = lanes[2]; d3 = lanes[3];
      for (int t = 0; t < 300; t++) begin
         if (in_ready) begin
            model_accept(first, lanes);
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
            return;
         end
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: in_ready stayed 0, required 1 within 300 cycles");
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic send_frame(input bit rnd);
      logic [3:0][DATA_W-1:0] lanes;
      for (int b = 0; b < 4; b++) begin
         for (int l = 0; l < 4; l++)
            lanes[l] = rnd ? DATA_W'($urandom) : {2{16'(4*l + b)}};
         drive_beat(b == 0, lanes);
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int t = 0; t < budget; t++) begin
         if (expq.size() == 0) begin
            repeat (3) @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d bins still pending, required 0", expq.size());
   endtask

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Scoreboard monitor.
   logic              prev_v = 1'b0, prev_r = 1'b0;
   logic [DATA_W-1:0] prev_d = '0;
   logic [3:0]        prev_i = '0;

   always @(negedge clk) begin
      if (!reset) begin
         prev_v  = 1'b0;
         cur_run = 0;
      end else begin
         if (frame_err) seen_err++;
         if (!in_ready) ready_low++;
         if (prev_v && !prev_r) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(data_out), 64'(prev_d));
            check("stall_index", 64'(out_index), 64'(prev_i));
         end
         if (out_valid) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
         end else begin
            cur_run = 0;
            check("idle_outputs_zero", 64'({data_out, out_index, out_last}), 64'd0);
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check("unexpected_bin_index", 64'(out_index), 64'hFFFF);
            end else begin
               exp_t e;
               e = expq.pop_front();
               check("bin_data", 64'(data_out), 64'(e.data));
               check("bin_index", 64'(out_index), 64'(e.k));
               check("bin_last", 64'(out_last), 64'(e.k == 15));
            end
         end
         prev_v = out_valid;
         prev_r = out_ready;
         prev_d = data_out;
         prev_i = out_index;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][DATA_W-1:0] lanes;
      int e0;

      // Reset state
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_outputs", 64'({data_out, out_index, out_last, frame_err}), 64'd0);
      #11 reset = 1'b1;
      @(negedge clk);
      check("in_ready_after_release", 64'(in_ready), 64'd1);

      // 1: single ramp frame, latency
      rdy_mode = 0;
      for (int b = 0; b < 4; b++) begin
         for (int l = 0; l < 4; l++) lanes[l] = {2{16'(4*l + b)}};
         if (b == 3) check("valid_before_last_beat", 64'(out_valid), 64'd0);
         drive_beat(b == 0, lanes);
      end
      check("latency_valid", 64'(out_valid), 64'd1);
      check("latency_index", 64'(out_index), 64'd0);
      wait_drain(200);

      // 2: four back-to-back frames, gapless output
      max_run   = 0;
      ready_low = 0;
      for (int f = 0; f < 4; f++) send_frame(1'b1);
      wait_drain(400);
      check("gapless_run", 64'(max_run), 64'd64);
      check("in_ready_dropped", 64'(ready_low > 0), 64'd1);

      // 3: random backpressure
      rdy_mode = 1;
      for (int f = 0; f < 3; f++) send_frame(1'b1);
      wait_drain(2000);
      rdy_mode = 0;

      // 4: resync on beat 2
      e0 = seen_err;
      lanes = {4{DATA_W'($urandom)}};
      drive_beat(1'b1, lanes);
      lanes = {4{DATA_W'($urandom)}};
      drive_beat(1'b0, lanes);
      send_frame(1'b1);
      wait_drain(200);
      check("frame_err_pulses", 64'(seen_err - e0), 64'd1);

      // 5: async reset mid-drain
      send_frame(1'b1);
      for (int t = 0; t < 100; t++) begin
         if (out_valid && out_index == 4'd7) break;
         @(negedge clk);
      end
      check("reached_index7", 64'(out_index), 64'd7);
      #2 reset = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_data", 64'(data_out), 64'd0);
      check("async_rst_in_ready", 64'(in_ready), 64'd0);
      expq.delete();
      mbeat = 0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      check("in_ready_after_rst2", 64'(in_ready), 64'd1);
      send_frame(1'b1);
      wait_drain(200);

      // 6: both banks full, extra beats ignored
      rdy_mode = 2;
      repeat (2) @(negedge clk);
      send_frame(1'b1);
      send_frame(1'b1);
      repeat (2) @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_out_valid", 64'(out_valid), 64'd1);
      for (int t = 0; t < 6; t++) begin
         in_valid = 1'b1;
         in_first = 1'($urandom_range(0, 1));
         d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
         @(negedge clk);
         check("full_ignore_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      rdy_mode = 0;
      wait_drain(400);

      check("queue_empty", 64'(expq.size()), 64'd0);
      check("frame_err_total", 64'(seen_err), 64'(exp_err));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
